bnn_conv_engine: RTL and testbench

- First binary convolution layer of the MNIST BNN; sits directly downstream of the pixel/weight loader.
- Starts on the loader's load_done and convolves the 28x28 binary image with eight 3x3 binary filters (valid padding, stride 1) using XNOR-popcount.
- Each window is thresholded to one activation bit. Bits are streamed out on a valid/ready interface to the next layer.

---
 rtl/bnn_pkg.sv | 10 +
 rtl/bnn_xnor_popcount.sv | 15 +
 rtl/bnn_conv_engine.sv | 136 +++++++++++++
 tb/tb_bnn_conv_engine.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared constants and types for the first binary convolution layer.
package bnn_pkg;
   localparam int IMG_DIM_C  = 28;
   localparam int KERNEL_C   = 3;
   localparam int NUM_FILT_C = 8;
   localparam int OUT_DIM_C  = IMG_DIM_C - KERNEL_C + 1;
   localparam int POOL_DIM_C = OUT_DIM_C / 2;
   typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} conv_state_t;
   typedef logic [KERNEL_C*KERNEL_C-1:0] window_t;
endpackage

// File: rtl/bnn_xnor_popcount.sv
// bnn_xnor_popcount: counts matching bits between a 3x3 binary window and a 3x3 binary filter.
module bnn_xnor_popcount
   import bnn_pkg::*;
(
   input  window_t    i_win,
   input  window_t    i_wt,
   output logic [3:0] o_cnt
);
   window_t w_match;
   assign w_match = i_win ~^ i_wt;
   always_comb begin
      o_cnt = '0;
      for (int k = 0; k < KERNEL_C*KERNEL_C; k++) o_cnt = o_cnt + {3'b000, w_match[k]};
   end
endmodule

// File: rtl/bnn_conv_engine.sv
// bnn_conv_engine: 3x3 XNOR-popcount convolution with thresholding, streamed one bit per transfer.
// Define BNN_CONV_MAXPOOL_EN to fuse a 2x2 stride-2 OR max-pool into the scan.
module bnn_conv_engine
   import bnn_pkg::*;
#(
   parameter int IMG_DIM  = IMG_DIM_C,
   parameter int NUM_FILT = NUM_FILT_C,
   parameter int THRESH   = 5
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [IMG_DIM*IMG_DIM-1:0]  pixels_flat,
   input  logic [NUM_FILT*9-1:0]       weights_flat,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_bit,
   output logic [2:0]                  out_filt,
   output logic [4:0]                  out_row,
   output logic [4:0]                  out_col,
   output logic                        busy,
   output logic                        done
);
   localparam int OUT_DIM = IMG_DIM - KERNEL_C + 1;
`ifdef BNN_CONV_MAXPOOL_EN
   localparam int GRID = OUT_DIM / 2;
`else
   localparam int GRID = OUT_DIM;
`endif
   localparam int PW = $clog2(IMG_DIM*IMG_DIM);
   localparam int WW = $clog2(NUM_FILT*9);
   localparam logic signed [4:0] TH = 5'(THRESH);

   conv_state_t r_state, w_next;
   logic [2:0]  r_filt, r_ofilt;
   logic [4:0]  r_row, r_col, r_orow, r_ocol, w_r, w_c;
   logic        r_bit, w_hit, w_col_end, w_row_end, w_last;
   window_t     w_win, w_wt;
   logic [3:0]  w_cnt;

`ifdef BNN_CONV_MAXPOOL_EN
   logic [1:0]  r_sub;
   logic        r_acc;
   // pooled counters select the 2x2 block; r_sub walks the four windows inside it
   assign w_r = {r_row[3:0], r_sub[1]};
   assign w_c = {r_col[3:0], r_sub[0]};
`else
   assign w_r = r_row;
   assign w_c = r_col;
`endif

   always_comb begin
      w_win = '0;
      w_wt  = '0;
      for (int k = 0; k < KERNEL_C*KERNEL_C; k++) begin
         w_win[k] = pixels_flat[PW'((int'(w_r) + k / KERNEL_C) * IMG_DIM + int'(w_c) + k % KERNEL_C)];
         w_wt[k]  = weights_flat[WW'(int'(r_filt) * 9 + k)];
      end
   end

   bnn_xnor_popcount u_pop (.i_win(w_win), .i_wt(w_wt), .o_cnt(w_cnt));

   assign w_hit     = $signed({1'b0, w_cnt}) >= TH;
   assign w_col_end = r_col == 5'(GRID-1);
   assign w_row_end = r_row == 5'(GRID-1);
   assign w_last    = w_col_end && w_row_end && r_filt == 3'(NUM_FILT-1);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? RUN : IDLE;
`ifdef BNN_CONV_MAXPOOL_EN
         RUN:     w_next = &r_sub ? HOLD : RUN;
`else
         RUN:     w_next = HOLD;
`endif
         HOLD:    w_next = out_ready ? (w_last ? DONE : RUN) : HOLD;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_filt  <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_bit   <= 1'b0;
         r_ofilt <= '0;
         r_orow  <= '0;
         r_ocol  <= '0;
`ifdef BNN_CONV_MAXPOOL_EN
         r_sub   <= '0;
         r_acc   <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && start) begin
            r_filt <= '0;
            r_row  <= '0;
            r_col  <= '0;
`ifdef BNN_CONV_MAXPOOL_EN
            r_sub  <= '0;
`endif
         end
         if (r_state == RUN) begin
`ifdef BNN_CONV_MAXPOOL_EN
            r_sub <= r_sub + 2'd1;
            r_acc <= (r_sub != 2'd0 && r_acc) || w_hit;
            if (&r_sub) r_bit <= r_acc || w_hit;
`else
            r_bit <= w_hit;
`endif
            r_ofilt <= r_filt;
            r_orow  <= r_row;
            r_ocol  <= r_col;
         end
         if (r_state == HOLD && out_ready && !w_last) begin
            r_col <= w_col_end ? '0 : r_col + 5'd1;
            if (w_col_end) begin
               r_row <= w_row_end ? '0 : r_row + 5'd1;
               if (w_row_end) r_filt <= r_filt + 3'd1;
            end
         end
      end
   end

   assign out_valid = r_state == HOLD;
   assign busy      = r_state == RUN || r_state == HOLD;
   assign done      = r_state == DONE;
   assign out_bit   = r_bit;
   assign out_filt  = r_ofilt;
   assign out_row   = r_orow;
   assign out_col   = r_ocol;
endmodule

// File: tb/tb_bnn_conv_engine.sv
// tb_bnn_conv_engine: scoreboard bench for bnn_conv_engine against a window-level reference model.
module tb_bnn_conv_engine;
   localparam int IMG = 28;
   localparam int NF  = 8;
   localparam int TH  = 5;
   localparam int OD  = IMG - 2;
`ifdef BNN_CONV_MAXPOOL_EN
   localparam int G    = OD / 2;
   localparam int BP_C = 12;
   localparam int LAT  = 4;
`else
   localparam int G    = OD;
   localparam int BP_C = 13;
   localparam int LAT  = 1;
`endif
   localparam int LIM = 60000;

   typedef struct packed {
      logic       b;
      logic [2:0] f;
      logic [4:0] r;
      logic [4:0] c;
   } item_t;

   logic clk = 0, reset = 1, start = 0, out_ready = 1;
   logic [IMG*IMG-1:0] pixels  = '0;
   logic [NF*9-1:0]    weights = '0;
   logic out_valid, out_bit, busy, done;
   logic [2:0] out_filt;
   logic [4:0] out_row, out_col;
   logic t0_valid, t0_bit, t0_busy, t0_done;
   logic [2:0] t0_filt;
   logic [4:0] t0_row, t0_col;

   item_t exp_q[$];
   int n_chk = 0, n_fail = 0, done_cnt = 0, xfer_cnt = 0;
   bit rnd_rdy = 0, bp_arm = 0;

   bnn_conv_engine dut (
      .clk(clk), .reset(reset), .start(start), .pixels_flat(pixels), .weights_flat(weights),
      .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_filt(out_filt),
      .out_row(out_row), .out_col(out_col), .busy(busy), .done(done));

   bnn_conv_engine #(.THRESH(0)) dut_t0 (
      .clk(clk), .reset(reset), .start(start), .pixels_flat(pixels), .weights_flat(weights),
      .out_valid(t0_valid), .out_ready(1'b1), .out_bit(t0_bit), .out_filt(t0_filt),
      .out_row(t0_row), .out_col(t0_col), .busy(t0_busy), .done(t0_done));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   function automatic logic win(int f, int r, int c);
      int m = 0;
      for (int kr = 0; kr < 3; kr++)
         for (int kc = 0; kc < 3; kc++)
            m += (pixels[(r + kr) * IMG + c + kc] == weights[f * 9 + kr * 3 + kc]) ? 1 : 0;
      return m >= TH;
   endfunction

   function automatic logic act(int f, int r, int c);
`ifdef BNN_CONV_MAXPOOL_EN
      return win(f, 2*r, 2*c) | win(f, 2*r, 2*c+1) | win(f, 2*r+1, 2*c) | win(f, 2*r+1, 2*c+1);
`else
      return win(f, r, c);
`endif
   endfunction

   task automatic fill_q();
      exp_q.delete();
      for (int f = 0; f < NF; f++)
         for (int r = 0; r < G; r++)
            for (int c = 0; c < G; c++)
               exp_q.push_back({act(f, r, c), 3'(f), 5'(r), 5'(c)});
   endtask

   task automatic randomize_img();
      for (int i = 0; i < IMG*IMG; i++) pixels[i] = 1'($urandom_range(1));
      for (int i = 0; i < NF*9; i++) weights[i] = 1'($urandom_range(1));
   endtask

   // scoreboard monitor: one pop per accepted transfer
   always @(negedge clk) begin
      item_t got;
      if (!reset) begin
         if (out_valid && out_ready) begin
            xfer_cnt++;
            got = {out_bit, out_filt, out_row, out_col};
            if (exp_q.size() == 0) check("queue_depth_at_xfer", 32'(exp_q.size()), 32'd1);
            else check("xfer", 32'(got), 32'(exp_q.pop_front()));
         end
         if (done) begin
            done_cnt++;
            check("busy_valid_at_done", 32'({busy, out_valid}), 32'd0);
         end
         if (t0_valid) check("thresh0_bit", 32'(t0_bit), 32'd1);
      end
   end

   // ready driver with a one-off 10-cycle stall at a fixed index
   initial begin
      item_t snap;
      forever begin
         @(posedge clk); #1;
         if (bp_arm && out_valid && out_filt == 3'd2 && out_row == 5'd7 && out_col == 5'(BP_C)) begin
            out_ready = 0;
            bp_arm = 0;
            snap = {out_bit, out_filt, out_row, out_col};
            repeat (10) begin
               @(negedge clk);
               check("bp_hold", 32'({out_valid, out_bit, out_filt, out_row, out_col}), 32'({1'b1, snap}));
               @(posedge clk); #1;
            end
            out_ready = 1;
         end else begin
            out_ready = rnd_rdy ? ($urandom_range(7) != 0) : 1'b1;
         end
      end
   end

   task automatic start_run();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      @(negedge clk);
      check("lat_busy", 32'({busy, out_valid}), 32'd2);
      repeat (LAT) @(negedge clk);
      check("lat_valid", 32'({busy, out_valid}), 32'd3);
   endtask

   task automatic wait_done(input int d0);
      int t = 0;
      while (done_cnt == d0 && t < LIM) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      check("done_pulses", 32'(done_cnt - d0), 32'd1);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run(input bit rr, input bit bp);
      int d0 = done_cnt;
      fill_q();
      rnd_rdy = rr;
      bp_arm = bp;
      start_run();
      wait_done(d0);
      if (bp) check("bp_seen", 32'(bp_arm), 32'd0);
      rnd_rdy = 0;
      bp_arm = 0;
   endtask

   initial begin
      int d0, x0, t;
      logic [8:0] p;
      repeat (3) @(negedge clk);
      check("reset_vals", 32'({out_valid, busy, done, out_bit, out_filt, out_row, out_col}), 32'd0);
      @(posedge clk); #1 reset = 0;

      pixels = '0; weights = '0;
      run(0, 0);

      pixels = '1; weights = '0;
      weights[3*9 +: 9] = '1;
      run(0, 0);

      // (0,0) window has 5 zeros: filter 0 (all 0) gives 5 matches, filter 1 gives 4
      randomize_img();
      p = 9'b110100100;
      for (int k = 0; k < 9; k++) pixels[(k / 3) * IMG + k % 3] = p[k];
      weights[0 +: 9] = 9'b000000000;
      weights[9 +: 9] = 9'b000000001;
      run(1, 1);

`ifdef BNN_CONV_MAXPOOL_EN
      pixels = '1; weights = '0;
      pixels[10 * IMG + 10] = 1'b0;
      run(0, 0);
`endif

      randomize_img();
      fill_q();
      d0 = done_cnt;
      x0 = xfer_cnt;
      start_run();
      t = 0;
      while (xfer_cnt < x0 + 1000 && t < LIM) begin
         @(posedge clk);
         t++;
      end
      check("reached_1000", 32'(xfer_cnt >= x0 + 1000), 32'd1);
      #1 reset = 1;
      @(negedge clk);
      check("reset_mid_run", 32'({out_valid, busy, done, out_bit, out_filt, out_row, out_col}), 32'd0);
      check("no_partial_done", 32'(done_cnt - d0), 32'd0);
      exp_q.delete();
      @(posedge clk); #1 reset = 0;
      randomize_img();
      run(0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
